// File: rtl/writeback_queue.sv
// Register write-back queue: merges ALU and load write requests into one register write port.
// Latency: an accepted request is presented on write/address/data the cycle after acceptance.
// Backpressure: ready drops only when full (no pass-through); the ALU wins over the load unit.
module writeback_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic [2:0]                alu_address,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    output logic                      alu_ready,
    input  logic                      mem_valid,
    input  logic [2:0]                mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      mem_ready,
    input  logic                      hold,
    output logic [2:0]                address,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      write,
    input  logic [2:0]                query_address,
    output logic                      query_pending,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]            address;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    entry_t          wr_entry;
    entry_t          head;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign alu_ready = !full;
    assign mem_ready = !full && !alu_valid;
    assign push      = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign pop       = !empty && !hold;
    assign wr_entry  = alu_valid ? entry_t'{alu_address, alu_data}
                                 : entry_t'{mem_address, mem_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            // push and pop never target the same slot: push needs !full, pop needs !empty
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head    = mem[rd_ptr];
    assign write   = pop;
    assign address = empty ? 3'd0 : head.address;
    assign data    = empty ? '0 : head.data;
    assign level   = count;

    always_comb begin
        query_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (mem[i].address == query_address)) query_pending = 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue with a queue-based reference and drain scoreboard.
module tb_writeback_queue;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]    a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid, hold;
    logic [2:0]    alu_address, mem_address, query_address;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready, write, query_pending;
    logic [2:0]    address;
    logic [DW-1:0] data;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;
    ent_t mq[$];     // reference contents, oldest first
    ent_t exp_q[$];  // scoreboard of expected drains

    writeback_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
        .hold(hold), .address(address), .data(data), .write(write),
        .query_address(query_address), .query_pending(query_pending), .level(level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented write must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && write) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL drain: write with nothing expected, got addr %0h data %0h", address, data);
            end else begin
                if (address !== exp_q[0].a || data !== exp_q[0].d) begin
                    bad++;
                    $display("FAIL drain: got addr %0h data %0h expected addr %0h data %0h",
                             address, data, exp_q[0].a, exp_q[0].d);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic av, input logic [2:0] aa, input logic [DW-1:0] ad,
                         input logic mv, input logic [2:0] ma, input logic [DW-1:0] md,
                         input logic h, input logic [2:0] qa);
        logic full, qp;
        ent_t e;
        alu_valid = av; alu_address = aa; alu_data = ad;
        mem_valid = mv; mem_address = ma; mem_data = md;
        hold = h; query_address = qa;
        @(negedge clock);
        full = (mq.size() == DEPTH);
        qp = 1'b0;
        foreach (mq[i]) if (mq[i].a == qa) qp = 1'b1;
        chk("level", 32'(level), 32'(mq.size()));
        chk("alu_ready", 32'(alu_ready), 32'(!full));
        chk("mem_ready", 32'(mem_ready), 32'(!full && !av));
        chk("write", 32'(write), 32'(mq.size() > 0 && !h));
        chk("query_pending", 32'(query_pending), 32'(qp));
        if (mq.size() == 0) begin
            chk("empty_address", 32'(address), 0);
            chk("empty_data", 32'(data), 0);
        end else begin
            chk("head_address", 32'(address), 32'(mq[0].a));
            chk("head_data", 32'(data), 32'(mq[0].d));
        end
        @(posedge clock);
        if (mq.size() > 0 && !h) void'(mq.pop_front());
        if (!full && (av || mv)) begin
            e = av ? ent_t'{aa, ad} : ent_t'{ma, md};
            mq.push_back(e);
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic h);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, h, 3'd0);
    endtask

    task automatic alu_req(input logic [2:0] a, input logic [DW-1:0] d, input logic h);
        cycle(1'b1, a, d, 1'b0, 3'd0, '0, h, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        alu_valid = 0; mem_valid = 0; hold = 0; query_address = 0;
        alu_address = 0; mem_address = 0; alu_data = 0; mem_data = 0;
        #3;
        chk("reset_level", 32'(level), 0);
        chk("reset_write", 32'(write), 0);
        chk("reset_alu_ready", 32'(alu_ready), 1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single ALU write, then it retires
        alu_req(3'd5, 16'h1234, 1'b0);
        chk("single_level", 32'(level), 1);
        chk("single_addr", 32'(address), 5);
        chk("single_data", 32'(data), 32'h1234);
        idle(1'b0);
        idle(1'b0);

        // ALU beats load; load accepted next cycle
        cycle(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd3, 16'h00BB, 1'b0, 3'd3);
        cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 16'h00BB, 1'b0, 3'd3);
        idle(1'b0);
        idle(1'b0);

        // Fill under hold, refuse fifth, drain, then wrap
        for (int i = 0; i < 4; i++) alu_req(3'(i), 16'(16'h0100 + i), 1'b1);
        chk("fill_level", 32'(level), 4);
        alu_req(3'd7, 16'hDEAD, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        alu_req(3'd4, 16'h4444, 1'b0);
        alu_req(3'd6, 16'h6666, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Full queue releasing hold with ALU waiting
        for (int i = 0; i < 4; i++) alu_req(3'(i + 1), 16'(16'h0200 + i), 1'b1);
        alu_req(3'd7, 16'h7777, 1'b0);
        chk("full_drain_level", 32'(level), 3);
        alu_req(3'd7, 16'h7777, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Pending query
        alu_req(3'd6, 16'h0606, 1'b1);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b1, 3'd6);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b1, 3'd4);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 3'd6);
        cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 3'd6);

        // Async reset between edges with three entries queued
        for (int i = 0; i < 3; i++) alu_req(3'd3, 16'(16'h0300 + i), 1'b1);
        alu_valid = 0; mem_valid = 0; query_address = 3'd3;
        reset = 1'b1;
        #2;
        chk("arst_level", 32'(level), 0);
        chk("arst_write", 32'(write), 0);
        chk("arst_address", 32'(address), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_query", 32'(query_pending), 0);
        chk("arst_mem_ready", 32'(mem_ready), 1);
        mq.delete();
        exp_q.delete();
        #1;
        reset = 1'b0;
        alu_req(3'd1, 16'hBEEF, 1'b0);
        idle(1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < 3), 3'($urandom));
        end
        for (int n = 0; n < DEPTH + 2; n++) idle(1'b0);
        @(negedge clock);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
